fetch_ctrl: RTL and testbench

- Sequences the program counter register and the instruction-memory port for the fetch stage.
- Issues word-addressed fetch requests over a req/ack handshake and advances the PC one word per accepted instruction.
- Applies branch/jump redirects from execute and holds fetched instructions during pipeline stalls.
- Drives the PC register's stall/branch_true/new_addr inputs and the IF/ID output registers.

---
 rtl/fetch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC register controls, the instruction-memory
// req/ack port and the IF/ID registers, with redirect, stall and skid handling.
module fetch_ctrl #(
  parameter int AW     = 32,
  parameter int IW     = 32,
  parameter int NSTALL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     pc_value,
  output logic              pc_stall,
  output logic              pc_branch_true,
  output logic [AW-1:0]     pc_new_addr,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_addr,
  input  logic [NSTALL-1:0] stall_req,
  output logic              imem_req,
  output logic [AW-1:0]     imem_addr,
  input  logic              imem_ack,
  input  logic [IW-1:0]     imem_rdata,
  output logic              if_valid,
  output logic [IW-1:0]     if_inst,
  output logic [AW-1:0]     if_pc,
  output logic              flush
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_imem_req;
  logic          w_imem_req_nxt;
  logic [AW-1:0] r_imem_addr;
  logic [AW-1:0] w_imem_addr_nxt;
  logic [IW-1:0] r_skid_inst;
  logic [IW-1:0] w_skid_inst_nxt;
  logic [AW-1:0] r_skid_pc;
  logic [AW-1:0] w_skid_pc_nxt;
  logic          r_if_valid;
  logic          w_if_valid_nxt;
  logic [IW-1:0] r_if_inst;
  logic [IW-1:0] w_if_inst_nxt;
  logic [AW-1:0] r_if_pc;
  logic [AW-1:0] w_if_pc_nxt;
  logic          w_deliver;
  logic [IW-1:0] w_del_inst;
  logic [AW-1:0] w_del_pc;
  logic          w_stall_any;
  logic          w_accept;

  assign w_stall_any = |stall_req;
  assign w_accept    = (r_state == S_REQ) && imem_ack;

  // PC controls are combinational; reset forces a held PC and no redirect.
  assign pc_stall       = rst ? !(redirect_valid || w_accept) : 1'b1;
  assign pc_branch_true = rst & redirect_valid;
  assign flush          = rst & redirect_valid;
  assign pc_new_addr    = rst ? redirect_addr : {AW{1'b0}};

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;

  // Fetch FSM: next state, request/address, skid buffer and the instruction to deliver.
  always_comb begin
    w_state_nxt     = r_state;
    w_imem_req_nxt  = r_imem_req;
    w_imem_addr_nxt = r_imem_addr;
    w_skid_inst_nxt = r_skid_inst;
    w_skid_pc_nxt   = r_skid_pc;
    w_deliver       = 1'b0;
    w_del_inst      = r_skid_inst;
    w_del_pc        = r_skid_pc;
    case (r_state)
      S_IDLE: begin
        if (!redirect_valid && !w_stall_any) begin
          w_imem_req_nxt  = 1'b1;
          w_imem_addr_nxt = pc_value;
          w_state_nxt     = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            w_imem_req_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end else if (w_stall_any) begin
            w_skid_inst_nxt = imem_rdata;
            w_skid_pc_nxt   = r_imem_addr;
            w_imem_req_nxt  = 1'b0;
            w_state_nxt     = S_HOLD;
          end else begin
            // PC equals imem_addr while a request is outstanding, so pc+1 is the next word.
            w_deliver       = 1'b1;
            w_del_inst      = imem_rdata;
            w_del_pc        = r_imem_addr;
            w_imem_addr_nxt = pc_value + {{(AW-1){1'b0}}, 1'b1};
            w_state_nxt     = S_REQ;
          end
        end else if (redirect_valid) begin
          w_state_nxt = S_DISCARD;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          w_imem_req_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_skid_inst_nxt = {IW{1'b0}};
          w_skid_pc_nxt   = {AW{1'b0}};
          w_state_nxt     = S_IDLE;
        end else if (!w_stall_any) begin
          w_deliver       = 1'b1;
          w_skid_inst_nxt = {IW{1'b0}};
          w_skid_pc_nxt   = {AW{1'b0}};
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_imem_req_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  // IF/ID update: redirect kills, stall freezes, otherwise load the delivered word or a bubble.
  always_comb begin
    w_if_valid_nxt = r_if_valid;
    w_if_inst_nxt  = r_if_inst;
    w_if_pc_nxt    = r_if_pc;
    if (redirect_valid) begin
      w_if_valid_nxt = 1'b0;
    end else if (!w_stall_any) begin
      w_if_valid_nxt = w_deliver;
      if (w_deliver) begin
        w_if_inst_nxt = w_del_inst;
        w_if_pc_nxt   = w_del_pc;
      end else begin
        w_if_inst_nxt = r_if_inst;
        w_if_pc_nxt   = r_if_pc;
      end
    end else begin
      w_if_valid_nxt = r_if_valid;
    end
  end

  // State, request, skid and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= {AW{1'b0}};
      r_skid_inst <= {IW{1'b0}};
      r_skid_pc   <= {AW{1'b0}};
      r_if_valid  <= 1'b0;
      r_if_inst   <= {IW{1'b0}};
      r_if_pc     <= {AW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_imem_req  <= w_imem_req_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_skid_inst <= w_skid_inst_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_pc     <= w_if_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage and an external PC register.
module tb_fetch_ctrl;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int NSTALL = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [AW-1:0]     pc_value;
  logic              pc_stall, pc_branch_true, flush;
  logic [AW-1:0]     pc_new_addr;
  logic              redirect_valid = 1'b0;
  logic [AW-1:0]     redirect_addr = 32'd0;
  logic [NSTALL-1:0] stall_req = 4'd0;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic              imem_ack = 1'b0;
  logic [IW-1:0]     imem_rdata = 32'd0;
  logic              if_valid;
  logic [IW-1:0]     if_inst;
  logic [AW-1:0]     if_pc;

  int checks = 0;
  int errors = 0;

  // Model state: outstanding request, whether it is killed, skid occupancy, IF/ID, PC.
  bit            m_req, m_kill, m_skid, m_ifv;
  logic [AW-1:0] m_addr, m_pc, m_skid_pc, m_ifp;
  logic [IW-1:0] m_skid_inst, m_ifi;
  bit            e_stall;
  bit            cur_redir, cur_ack;
  logic [AW-1:0] cur_raddr;
  logic [NSTALL-1:0] cur_stall;
  logic [IW-1:0] cur_rdata;

  fetch_ctrl #(.AW(AW), .IW(IW), .NSTALL(NSTALL)) dut (
    .clk(clk), .rst(rst), .pc_value(pc_value), .pc_stall(pc_stall),
    .pc_branch_true(pc_branch_true), .pc_new_addr(pc_new_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall_req(stall_req), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  // External PC register controlled by the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_value <= 32'd0;
    else if (!pc_stall) pc_value <= pc_branch_true ? pc_new_addr : pc_value + 32'd1;
  end

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic model_reset();
    m_req = 1'b0; m_kill = 1'b0; m_skid = 1'b0; m_ifv = 1'b0;
    m_addr = 32'd0; m_pc = 32'd0; m_skid_pc = 32'd0; m_ifp = 32'd0;
    m_skid_inst = 32'd0; m_ifi = 32'd0;
  endtask

  // Apply one cycle of inputs (called at a falling edge); the memory only acks a live request.
  task automatic drive(input bit redir, input logic [AW-1:0] raddr,
                       input logic [NSTALL-1:0] stall, input bit ack);
    cur_redir = redir; cur_raddr = raddr; cur_stall = stall;
    cur_ack   = ack && (imem_req === 1'b1);
    cur_rdata = cur_ack ? mem_word(imem_addr) : IW'($urandom);
    redirect_valid = cur_redir; redirect_addr = cur_raddr;
    stall_req = cur_stall; imem_ack = cur_ack; imem_rdata = cur_rdata;
    #1;
    e_stall = !(cur_redir || (m_req && !m_kill && cur_ack));
  endtask

  // Advance the model by one clock using the applied inputs, then move to the next falling edge.
  task automatic advance();
    bit stall_any;
    bit deliver;
    logic [IW-1:0] d_i;
    logic [AW-1:0] d_p;
    logic [AW-1:0] pc_old;
    stall_any = |cur_stall; deliver = 1'b0; d_i = 32'd0; d_p = 32'd0; pc_old = m_pc;
    if (cur_redir) m_pc = cur_raddr;
    else if (m_req && !m_kill && cur_ack) m_pc = m_pc + 32'd1;
    if (m_req) begin
      if (cur_ack) begin
        if (m_kill || cur_redir) begin
          m_req = 1'b0; m_kill = 1'b0;
        end else if (stall_any) begin
          m_skid = 1'b1; m_skid_inst = cur_rdata; m_skid_pc = m_addr; m_req = 1'b0;
        end else begin
          deliver = 1'b1; d_i = cur_rdata; d_p = m_addr; m_addr = pc_old + 32'd1;
        end
      end else if (cur_redir) begin
        m_kill = 1'b1;
      end
    end else if (m_skid) begin
      if (cur_redir) m_skid = 1'b0;
      else if (!stall_any) begin
        deliver = 1'b1; d_i = m_skid_inst; d_p = m_skid_pc; m_skid = 1'b0;
      end
    end else if (!cur_redir && !stall_any) begin
      m_req = 1'b1; m_addr = pc_old;
    end
    if (cur_redir) m_ifv = 1'b0;
    else if (!stall_any) begin
      m_ifv = deliver;
      if (deliver) begin m_ifi = d_i; m_ifp = d_p; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    drive(1'b1, 32'h0000_1234, 4'd0, 1'b0);
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_pc_stall: got %b want 1", pc_stall); end
    checks++; if (pc_branch_true !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_branch_flush: got %b%b want 00", pc_branch_true, flush); end
    checks++; if (pc_new_addr !== 32'd0) begin errors++; $display("FAIL rst_new_addr: got %h want 0", pc_new_addr); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL rst_imem: got %b/%h want 0/0", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'd0 || if_pc !== 32'd0) begin errors++; $display("FAIL rst_ifid: got %b/%h/%h want 0/0/0", if_valid, if_inst, if_pc); end
    @(negedge clk);
    redirect_valid = 1'b0; redirect_addr = 32'd0;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'd0, 4'd0, 1'b1);
      checks++; if (imem_req !== (i >= 1)) begin errors++; $display("FAIL stream_req[%0d]: got %b want %b", i, imem_req, i >= 1); end
      if (i >= 1) begin
        checks++; if (imem_addr !== AW'(i - 1)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, i - 1); end
        checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL stream_pc_stall[%0d]: got %b want 0", i, pc_stall); end
      end
      if (i >= 2) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== AW'(i - 2) || if_inst !== mem_word(AW'(i - 2))) begin
          errors++; $display("FAIL stream_ifid[%0d]: got %b/%h/%h want 1/%h/%h", i, if_valid, if_pc, if_inst, i - 2, mem_word(AW'(i - 2)));
        end
      end
      advance();
    end
  endtask

  task automatic test_wait_ack();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 4'd0, i == 3);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin errors++; $display("FAIL wait_req[%0d]: got %b/%h want 1/5", i, imem_req, imem_addr); end
      checks++; if (pc_stall !== (i != 3)) begin errors++; $display("FAIL wait_pc_stall[%0d]: got %b want %b", i, pc_stall, i != 3); end
      advance();
    end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd5 || if_inst !== mem_word(32'd5)) begin
      errors++; $display("FAIL wait_ifid: got %b/%h/%h want 1/5/%h", if_valid, if_pc, if_inst, mem_word(32'd5));
    end
  endtask

  task automatic test_redirect_outstanding();
    drive(1'b0, 32'd0, 4'd0, 1'b1); advance();
    drive(1'b1, 32'h40, 4'd0, 1'b0);
    checks++; if (imem_addr !== 32'd7) begin errors++; $display("FAIL redir_old_addr: got %h want 7", imem_addr); end
    checks++; if (flush !== 1'b1 || pc_branch_true !== 1'b1 || pc_new_addr !== 32'h40) begin
      errors++; $display("FAIL redir_pulse: got %b/%b/%h want 1/1/40", flush, pc_branch_true, pc_new_addr);
    end
    advance();
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    checks++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd7 || if_valid !== 1'b0) begin
      errors++; $display("FAIL redir_discard: got %b/%b/%h/%b want 0/1/7/0", flush, imem_req, imem_addr, if_valid);
    end
    advance();
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL redir_discard_stall: got %b want 1", pc_stall); end
    advance();
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped: got %b/%b want 0/0", imem_req, if_valid); end
    advance();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_next: got %b/%h want 1/40", imem_req, imem_addr); end
  endtask

  task automatic test_hold_stall();
    drive(1'b1, 32'd2, 4'd0, 1'b1); advance();
    drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    drive(1'b0, 32'd0, 4'd0, 1'b1); advance();
    drive(1'b0, 32'd0, 4'b0010, 1'b1);
    checks++; if (imem_addr !== 32'd3) begin errors++; $display("FAIL hold_addr: got %h want 3", imem_addr); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 4'b0010, 1'b0);
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'd2 || if_inst !== mem_word(32'd2)) begin
        errors++; $display("FAIL hold_frozen[%0d]: got %b/%b/%h/%h want 0/1/2/%h", i, imem_req, if_valid, if_pc, if_inst, mem_word(32'd2));
      end
      advance();
    end
    drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'd3 || if_inst !== mem_word(32'd3)) begin
      errors++; $display("FAIL hold_release: got %b/%h/%h want 1/3/%h", if_valid, if_pc, if_inst, mem_word(32'd3));
    end
    drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL hold_next: got %b/%h want 1/4", imem_req, imem_addr); end
  endtask

  task automatic test_hold_redirect();
    drive(1'b0, 32'd0, 4'b1000, 1'b1); advance();
    drive(1'b1, 32'h80, 4'b1000, 1'b0);
    checks++; if (flush !== 1'b1 || pc_branch_true !== 1'b1 || pc_stall !== 1'b0) begin
      errors++; $display("FAIL hredir_pulse: got %b/%b/%b want 1/1/0", flush, pc_branch_true, pc_stall);
    end
    advance();
    checks++; if (if_valid !== 1'b0 || pc_value !== 32'h80) begin errors++; $display("FAIL hredir_kill: got %b/%h want 0/80", if_valid, pc_value); end
    drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++; $display("FAIL hredir_next: got %b/%b/%h want 0/1/80", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1); advance();
    drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    drive(1'b0, 32'd0, 4'd0, 1'b1);
    checks++; if (imem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_addr: got %h want ffffffff", imem_addr); end
    advance();
    checks++; if (imem_addr !== 32'd0 || pc_value !== 32'd0 || if_pc !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_next: got %h/%h/%h want 0/0/ffffffff", imem_addr, pc_value, if_pc);
    end
  endtask

  task automatic test_random();
    bit r; logic [AW-1:0] ra; logic [NSTALL-1:0] st; bit ak;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(7) == 0);
      ra = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF - AW'($urandom_range(2)) : AW'($urandom_range(255));
      st = ($urandom_range(3) == 0) ? NSTALL'($urandom) : 4'd0;
      ak = ($urandom_range(1) == 0);
      drive(r, ra, st, ak);
      checks++; if (imem_req !== m_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, m_req); end
      checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_addr); end
      checks++; if (if_valid !== m_ifv) begin errors++; $display("FAIL rnd_if_valid[%0d]: got %b want %b", i, if_valid, m_ifv); end
      checks++; if (if_inst !== m_ifi) begin errors++; $display("FAIL rnd_if_inst[%0d]: got %h want %h", i, if_inst, m_ifi); end
      checks++; if (if_pc !== m_ifp) begin errors++; $display("FAIL rnd_if_pc[%0d]: got %h want %h", i, if_pc, m_ifp); end
      checks++; if (pc_stall !== e_stall) begin errors++; $display("FAIL rnd_pc_stall[%0d]: got %b want %b", i, pc_stall, e_stall); end
      checks++; if (pc_branch_true !== cur_redir || flush !== cur_redir) begin errors++; $display("FAIL rnd_branch_flush[%0d]: got %b%b want %b", i, pc_branch_true, flush, cur_redir); end
      checks++; if (pc_new_addr !== cur_raddr) begin errors++; $display("FAIL rnd_new_addr[%0d]: got %h want %h", i, pc_new_addr, cur_raddr); end
      checks++; if (pc_value !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_value, m_pc); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6 && !m_req; i++) begin
      drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL areset_setup: got %b want 1", imem_req); end
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0 || if_valid !== 1'b0 || pc_stall !== 1'b1) begin
      errors++; $display("FAIL areset_now: got %b/%h/%b/%b want 0/0/0/1", imem_req, imem_addr, if_valid, pc_stall);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 4'd0, 1'b0); advance();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL areset_restart: got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_wait_ack();
    test_redirect_outstanding();
    test_hold_stall();
    test_hold_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
